// File: rtl/periph_pwm_multi_if.sv
// PicoMmIf: simple memory-mapped slave bus carrying clock and synchronous reset.
// The byte address and the data buses are 32 bits wide. Read data is registered by the slave.
interface PicoMmIf (
   input logic clk,
   input logic rst
);
   logic [31:0] addr;
   logic        write;
   logic [31:0] wrdata;
   logic [31:0] rddata;

   modport slave (
      input  clk,
      input  rst,
      input  addr,
      input  write,
      input  wrdata,
      output rddata
   );

   modport master (
      input  clk,
      input  rst,
      output addr,
      output write,
      output wrdata,
      input  rddata
   );
endinterface

// File: rtl/periph_pwm_multi.sv
// periph_pwm_multi: NCH-channel PWM peripheral on a PicoMmIf slave port.
// Each channel has shadowed PERIOD/DUTY registers. The shadow values are committed
// only at period wrap. Each channel also has EN/INV control and a live counter readback.
// STATUS holds sticky per-channel carry-outs and is cleared by writing 1.
module periph_pwm_multi #(
   parameter int NCH = 4,
   parameter int W   = 32
) (
   PicoMmIf.slave         s,
   output logic [NCH-1:0] pwm,
   output logic [NCH-1:0] co
);
   localparam int WAW = 30;

   logic [WAW-1:0] wa;
   logic [W-1:0]   per_s  [NCH];
   logic [W-1:0]   duty_s [NCH];
   logic [W-1:0]   per_a  [NCH];
   logic [W-1:0]   duty_a [NCH];
   logic [W-1:0]   cnt    [NCH];
   logic [NCH-1:0] en;
   logic [NCH-1:0] inv;
   logic [NCH-1:0] sts;
   logic [NCH-1:0] run;
   logic [31:0]    rd_n;

   assign wa = s.addr[31:2];

   // Per-channel run state, carry-out and PWM level, derived from registered state only
   always_comb begin
      run = '0;
      co  = '0;
      pwm = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         run[c] = en[c] && (per_a[c] != '0);
         co[c]  = run[c] && (cnt[c] == per_a[c] - W'(1));
         pwm[c] = inv[c] ^ (run[c] && (cnt[c] < duty_a[c]));
      end
   end

   // Read mux: registers zero-extended to 32 bits, unmapped words read 0
   always_comb begin
      rd_n = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (wa == WAW'(4 * c))     rd_n = 32'(per_s[c]);
         if (wa == WAW'(4 * c + 1)) rd_n = 32'(duty_s[c]);
         if (wa == WAW'(4 * c + 2)) rd_n = 32'({inv[c], en[c]});
         if (wa == WAW'(4 * c + 3)) rd_n = 32'(cnt[c]);
      end
      if (wa == WAW'(4 * NCH)) rd_n = 32'(sts);
   end

   // Register writes, counters with shadow commit at wrap, sticky status, registered read data
   always_ff @(posedge s.clk) begin
      if (s.rst) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            per_s[c]  <= '0;
            duty_s[c] <= '0;
            per_a[c]  <= '0;
            duty_a[c] <= '0;
            cnt[c]    <= '0;
         end
         en       <= '0;
         inv      <= '0;
         sts      <= '0;
         s.rddata <= '0;
      end else begin
         for (int unsigned c = 0; c < NCH; c++) begin
            if (s.write && wa == WAW'(4 * c))     per_s[c]  <= s.wrdata[W-1:0];
            if (s.write && wa == WAW'(4 * c + 1)) duty_s[c] <= s.wrdata[W-1:0];
            if (s.write && wa == WAW'(4 * c + 2)) begin
               en[c]  <= s.wrdata[0];
               inv[c] <= s.wrdata[1];
            end
            // Idle or zero-period channels track the shadow every cycle.
            // Running channels commit the pre-write shadow only on their wrap cycle.
            if (!run[c]) begin
               cnt[c]    <= '0;
               per_a[c]  <= per_s[c];
               duty_a[c] <= duty_s[c];
            end else if (co[c]) begin
               cnt[c]    <= '0;
               per_a[c]  <= per_s[c];
               duty_a[c] <= duty_s[c];
            end else begin
               cnt[c] <= cnt[c] + W'(1);
            end
         end
         // A carry-out in the same cycle as a clear leaves the bit set
         if (s.write && wa == WAW'(4 * NCH))
            sts <= (sts & ~s.wrdata[NCH-1:0]) | co;
         else
            sts <= sts | co;
         s.rddata <= rd_n;
      end
   end
endmodule

// File: tb/tb_periph_pwm_multi.sv
// Self-checking bench for periph_pwm_multi (NCH=4, W=32).
// Expected read data is queued when a read is presented and compared one cycle later.
// PWM and carry-out levels are checked each cycle against per-scenario arithmetic.
module tb_periph_pwm_multi;
   localparam int NCH = 4;
   localparam int W   = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NCH-1:0] pwm;
   logic [NCH-1:0] co;
   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] rq [$];
   string       rn [$];

   PicoMmIf bus (.clk(clk), .rst(rst));

   periph_pwm_multi #(.NCH(NCH), .W(W)) dut (
      .s   (bus),
      .pwm (pwm),
      .co  (co)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.write = 1'b0;
      bus.addr = '0;
      bus.wrdata = '0;
      rq.delete();
      rn.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.write = 1'b1;
      bus.addr = a;
      bus.wrdata = d;
      @(negedge clk);
      bus.write = 1'b0;
   endtask

   task automatic present_rd(input logic [31:0] a, input logic [31:0] e, input string nm);
      bus.write = 1'b0;
      bus.addr = a;
      rq.push_back(e);
      rn.push_back(nm);
   endtask

   task automatic test_reset();
      logic [31:0] e;
      string nm;
      do_reset();
      n_cmp++;
      if (pwm !== 4'b0000 || co !== 4'b0000 || bus.rddata !== 32'h0) begin
         n_err++;
         $display("FAIL reset_outputs: pwm=%b co=%b rddata=%h expected 0000 0000 00000000", pwm, co, bus.rddata);
      end
      for (int k = 0; k < 19; k++) begin
         if (rq.size() != 0) begin
            e = rq.pop_front(); nm = rn.pop_front(); n_cmp++;
            if (bus.rddata !== e) begin
               n_err++;
               $display("FAIL %s: rddata=%h expected %h", nm, bus.rddata, e);
            end
         end
         if (k < 18) present_rd(32'(k * 4), 32'h0, $sformatf("reset_read wa=%0d", k));
         @(negedge clk);
      end
   endtask

   task automatic test_regs();
      logic [31:0] e;
      string nm;
      do_reset();
      wr(32'd40, 32'hFFFF_FFFF);
      wr(32'd48, 32'hDEAD_BEEF);
      wr(32'd44, 32'h0000_0055);
      for (int k = 0; k < 6; k++) begin
         n_cmp++;
         if (pwm !== 4'b0100 || co !== 4'b0000) begin
            n_err++;
            $display("FAIL regs_zero_period k=%0d: pwm=%b co=%b expected 0100 0000", k, pwm, co);
         end
         if (rq.size() != 0) begin
            e = rq.pop_front(); nm = rn.pop_front(); n_cmp++;
            if (bus.rddata !== e) begin
               n_err++;
               $display("FAIL %s: rddata=%h expected %h", nm, bus.rddata, e);
            end
         end
         case (k)
            0: present_rd(32'd40, 32'h0000_0003, "regs_ctrl2");
            1: present_rd(32'd44, 32'h0000_0000, "regs_count2");
            2: present_rd(32'd48, 32'hDEAD_BEEF, "regs_period3");
            3: present_rd(32'd52, 32'h0000_0000, "regs_duty3");
            4: present_rd(32'd80, 32'h0000_0000, "regs_unmapped");
            default: ;
         endcase
         @(negedge clk);
      end
   endtask

   task automatic test_basic();
      logic [3:0] ep, ec;
      do_reset();
      wr(32'd0, 32'd10);
      wr(32'd4, 32'd3);
      wr(32'd8, 32'd1);
      for (int k = 0; k < 30; k++) begin
         ep = ((k % 10) < 3) ? 4'b0001 : 4'b0000;
         ec = ((k % 10) == 9) ? 4'b0001 : 4'b0000;
         n_cmp++;
         if (pwm !== ep || co !== ec) begin
            n_err++;
            $display("FAIL basic k=%0d: pwm=%b co=%b expected %b %b", k, pwm, co, ep, ec);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_duty_update();
      logic [3:0] ep, ec;
      do_reset();
      wr(32'd0, 32'd10);
      wr(32'd4, 32'd3);
      wr(32'd8, 32'd1);
      for (int k = 0; k < 30; k++) begin
         if (k < 10) ep = ((k % 10) < 3) ? 4'b0001 : 4'b0000;
         else        ep = ((k % 10) < 7) ? 4'b0001 : 4'b0000;
         ec = ((k % 10) == 9) ? 4'b0001 : 4'b0000;
         n_cmp++;
         if (pwm !== ep || co !== ec) begin
            n_err++;
            $display("FAIL duty_update k=%0d: pwm=%b co=%b expected %b %b", k, pwm, co, ep, ec);
         end
         bus.write = 1'b0;
         if (k == 4) begin
            bus.write = 1'b1; bus.addr = 32'd4; bus.wrdata = 32'd7;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_invert();
      logic [3:0] ep, ec;
      do_reset();
      wr(32'd0, 32'd10);
      wr(32'd4, 32'd0);
      wr(32'd8, 32'd3);
      for (int k = 0; k < 50; k++) begin
         // DUTY=12 is written in the wrap cycle 19, so it commits only at wrap 29
         ep = (k < 30) ? 4'b0001 : 4'b0000;
         ec = ((k % 10) == 9) ? 4'b0001 : 4'b0000;
         n_cmp++;
         if (pwm !== ep || co !== ec) begin
            n_err++;
            $display("FAIL invert k=%0d: pwm=%b co=%b expected %b %b", k, pwm, co, ep, ec);
         end
         bus.write = 1'b0;
         if (k == 19) begin
            bus.write = 1'b1; bus.addr = 32'd4; bus.wrdata = 32'd12;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_status();
      logic [3:0] ec;
      logic [31:0] e;
      string nm;
      do_reset();
      wr(32'd16, 32'd4);
      wr(32'd24, 32'd1);
      for (int k = 0; k < 15; k++) begin
         ec = ((k % 4) == 3) ? 4'b0010 : 4'b0000;
         n_cmp++;
         if (co !== ec) begin
            n_err++;
            $display("FAIL status_co k=%0d: co=%b expected %b", k, co, ec);
         end
         if (rq.size() != 0) begin
            e = rq.pop_front(); nm = rn.pop_front(); n_cmp++;
            if (bus.rddata !== e) begin
               n_err++;
               $display("FAIL %s: rddata=%h expected %h", nm, bus.rddata, e);
            end
         end
         bus.write = 1'b0;
         case (k)
            8:  present_rd(32'd64, 32'h2, "status_after_two_wraps");
            9:  begin bus.write = 1'b1; bus.addr = 32'd64; bus.wrdata = 32'h2; end
            10: present_rd(32'd64, 32'h0, "status_after_clear");
            11: begin bus.write = 1'b1; bus.addr = 32'd64; bus.wrdata = 32'h2; end
            12: present_rd(32'd64, 32'h2, "status_set_wins");
            13: present_rd(32'd64, 32'h2, "status_still_set");
            default: ;
         endcase
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      string nm;
      do_reset();
      wr(32'd0, 32'd5);
      wr(32'd8, 32'd1);
      for (int k = 0; k < 10; k++) begin
         if (rq.size() != 0) begin
            e = rq.pop_front(); nm = rn.pop_front(); n_cmp++;
            if (bus.rddata !== e) begin
               n_err++;
               $display("FAIL %s: rddata=%h expected %h", nm, bus.rddata, e);
            end
         end
         bus.write = 1'b0;
         if (k <= 5) present_rd(32'd12, 32'(k % 5), $sformatf("count_read k=%0d", k));
         else if (k == 6) present_rd(32'd68, 32'h0, "status_plus_one_read");
         else if (k == 7) begin bus.write = 1'b1; bus.addr = 32'd12; bus.wrdata = 32'h1; end
         else if (k == 8) present_rd(32'd12, 32'h3, "count_write_ignored");
         @(negedge clk);
      end
   endtask

   task automatic test_mid_reset();
      logic [3:0] ep, ec;
      logic [31:0] e;
      string nm;
      do_reset();
      wr(32'd0, 32'd10);
      wr(32'd4, 32'd3);
      wr(32'd8, 32'd1);
      for (int k = 0; k < 25; k++) begin
         ep = (k <= 12 && (k % 10) < 3) ? 4'b0001 : 4'b0000;
         ec = (k <= 12 && (k % 10) == 9) ? 4'b0001 : 4'b0000;
         n_cmp++;
         if (pwm !== ep || co !== ec) begin
            n_err++;
            $display("FAIL mid_reset k=%0d: pwm=%b co=%b expected %b %b", k, pwm, co, ep, ec);
         end
         if (k == 13) begin
            n_cmp++;
            if (bus.rddata !== 32'h0) begin
               n_err++;
               $display("FAIL mid_reset_rddata: rddata=%h expected 00000000", bus.rddata);
            end
         end
         if (rq.size() != 0) begin
            e = rq.pop_front(); nm = rn.pop_front(); n_cmp++;
            if (bus.rddata !== e) begin
               n_err++;
               $display("FAIL %s: rddata=%h expected %h", nm, bus.rddata, e);
            end
         end
         bus.write = 1'b0;
         if (k == 12) rst = 1'b1;
         if (k == 13) rst = 1'b0;
         case (k)
            13: present_rd(32'd0,  32'h0, "mid_reset_period0");
            14: present_rd(32'd4,  32'h0, "mid_reset_duty0");
            15: present_rd(32'd8,  32'h0, "mid_reset_ctrl0");
            16: present_rd(32'd12, 32'h0, "mid_reset_count0");
            17: present_rd(32'd64, 32'h0, "mid_reset_status");
            default: ;
         endcase
         @(negedge clk);
      end
   endtask

   initial begin
      bus.addr = '0;
      bus.write = 1'b0;
      bus.wrdata = '0;
      test_reset();
      test_regs();
      test_basic();
      test_duty_update();
      test_invert();
      test_status();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
